uart_frame_rx_param: RTL and testbench

//  Parametrised UART frame receiver and successor to the fixed 14-byte receiver/decoder.

---
 rtl/uart_frame_rx_param.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_frame_rx_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx_param.sv
// 8N1 UART receiver with a parametrised frame decoder. It checks the header, tail and checksum,
// aborts on framing errors or an inter-byte timeout, and presents the payload as a flat vector.
module uart_frame_rx_param #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         UART_BPS     = 115200,
  parameter int         FRAME_LEN    = 14,
  parameter logic [7:0] HEAD_BYTE    = 8'h55,
  parameter logic [7:0] TAIL_BYTE    = 8'hAA,
  parameter bit         CHK_EN       = 1'b1,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        uart_rxd,
  output logic [7:0]                  byte_data,
  output logic                        byte_valid,
  output logic                        busy,
  output logic [8*(FRAME_LEN-2)-1:0]  frame_data,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic [2:0]                  err_code
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int PAY_LEN  = FRAME_LEN - 2;
  localparam int CNT_W    = $clog2(BPS_CNT + 1);
  localparam int IDX_W    = $clog2(FRAME_LEN + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_MID      = CNT_W'(BPS_CNT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BPS_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_TAIL     = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_SUM_LAST = IDX_W'(FRAME_LEN - 3);
  localparam logic [TO_W-1:0]  TO_MAX       = TO_W'(TO_LIMIT);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [1:0] {F_HUNT, F_COLLECT, F_CHECK} fstate_t;

  // ---------------- input synchroniser ----------------
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic start_edge;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign start_edge = rxd_prev_q & ~rxd_sync_q;

  // ---------------- byte FSM ----------------
  bstate_t          bstate_q, bstate_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             ferr_q, ferr_d;
  logic             bit_mid, bit_last;

  assign bit_mid  = (bit_cnt_q == CNT_MID);
  assign bit_last = (bit_cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bstate_q     <= B_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      bstate_q     <= bstate_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
    end
  end

  always_comb begin
    bstate_d = bstate_q;
    case (bstate_q)
      B_IDLE:  if (start_edge) bstate_d = B_START;
      B_START: begin
        if (bit_mid && rxd_sync_q) bstate_d = B_IDLE;
        else if (bit_last)         bstate_d = B_DATA;
      end
      B_DATA:  if (bit_last && bit_idx_q == 3'd7) bstate_d = B_STOP;
      B_STOP:  if (bit_mid) bstate_d = B_IDLE;
      default: bstate_d = B_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d    = bit_last ? '0 : bit_cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
    case (bstate_q)
      B_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
      end
      B_START: begin
        if (bit_mid && rxd_sync_q) bit_cnt_d = '0;
      end
      B_DATA: begin
        if (bit_mid)  shreg_d   = {rxd_sync_q, shreg_q[7:1]};
        if (bit_last) bit_idx_d = bit_idx_q + 1'b1;
      end
      B_STOP: begin
        if (bit_mid) begin
          bit_cnt_d = '0;
          if (rxd_sync_q) begin
            byte_data_d  = shreg_q;
            byte_valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: bit_cnt_d = '0;
    endcase
  end

  // ---------------- frame FSM ----------------
  fstate_t            fstate_q, fstate_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [8*PAY_LEN-1:0] pay_q, pay_d;
  logic [8*PAY_LEN-1:0] frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               is_head, timeout_hit;

  assign is_head     = byte_valid_q && (byte_data_q == HEAD_BYTE);
  // Expiry only aborts between bytes; a byte already on the wire gets to finish.
  assign timeout_hit = (to_cnt_q == TO_MAX) && (bstate_q == B_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fstate_q      <= F_HUNT;
      idx_q         <= '0;
      sum_q         <= '0;
      pay_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 3'd0;
      to_cnt_q      <= '0;
    end else begin
      fstate_q      <= fstate_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      pay_q         <= pay_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  always_comb begin
    fstate_d = fstate_q;
    case (fstate_q)
      F_HUNT:    if (is_head) fstate_d = F_COLLECT;
      F_COLLECT: begin
        if (byte_valid_q) begin
          if (idx_q == IDX_TAIL) fstate_d = F_CHECK;
        end else if (ferr_q || timeout_hit) begin
          fstate_d = F_HUNT;
        end
      end
      F_CHECK:   fstate_d = F_HUNT;
      default:   fstate_d = F_HUNT;
    endcase
  end

  always_comb begin
    idx_d         = idx_q;
    sum_d         = sum_q;
    pay_d         = pay_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    to_cnt_d      = '0;
    case (fstate_q)
      F_HUNT: begin
        if (is_head) begin
          idx_d = IDX_W'(1);
          sum_d = '0;
        end
      end
      F_COLLECT: begin
        if (byte_valid_q) begin
          idx_d = idx_q + 1'b1;
          if (idx_q != IDX_TAIL) begin
            for (int i = 0; i < PAY_LEN; i++) begin
              if (idx_q == IDX_W'(i + 1)) pay_d[8*i +: 8] = byte_data_q;
            end
            if (idx_q <= IDX_SUM_LAST) sum_d = sum_q + byte_data_q;
          end else if (byte_data_q != TAIL_BYTE) begin
            frame_err_d = 1'b1;
            err_code_d  = 3'd2;
          end else if (CHK_EN && (pay_q[8*PAY_LEN-1 -: 8] != sum_q)) begin
            frame_err_d = 1'b1;
            err_code_d  = 3'd3;
          end else begin
            frame_data_d  = pay_q;
            frame_valid_d = 1'b1;
            err_code_d    = 3'd0;
          end
        end else if (ferr_q) begin
          frame_err_d = 1'b1;
          err_code_d  = 3'd1;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 3'd4;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      default: ;
    endcase
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign busy        = (fstate_q != F_HUNT);
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_rx_param.sv
// Directed bench for uart_frame_rx_param with 6-byte frames and a short bit period.
// It runs a table of whole frames, then hand sequences for timeout, framing, glitch and reset.
module tb_uart_frame_rx_param;
  localparam int CLK_FREQ  = 50_000_000;
  localparam int UART_BPS  = 1_000_000;
  localparam int BPS       = CLK_FREQ / UART_BPS;
  localparam int FRAME_LEN = 6;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        uart_rxd;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        busy;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic [2:0]  err_code;

  uart_frame_rx_param #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .FRAME_LEN(FRAME_LEN),
    .HEAD_BYTE(8'h55), .TAIL_BYTE(8'hAA), .CHK_EN(1'b1), .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd),
    .byte_data(byte_data), .byte_valid(byte_valid), .busy(busy),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0, fe_cnt = 0, bv_cnt = 0;
  int fv0, fe0, bv0;

  always @(negedge sys_clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (byte_valid)  bv_cnt <= bv_cnt + 1;
  end

  typedef struct {
    logic [63:0] bytes;     // byte 0 in bits [7:0]
    int          n;
    int          exp_fv;
    int          exp_fe;
    logic [2:0]  exp_code;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic hold_bits(input int nbits);
    repeat (nbits * BPS) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    uart_rxd = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      hold_bits(1);
    end
    uart_rxd = stop_v;
    hold_bits(1);
    uart_rxd = 1'b1;
    hold_bits(1);
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*i +: 8], 1'b1);
  endtask

  task automatic snap();
    #1;
    fv0 = fv_cnt; fe0 = fe_cnt; bv0 = bv_cnt;
  endtask

  task automatic settle();
    repeat (5) @(negedge sys_clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int efv, input int efe,
                             input logic [2:0] ecode, input logic [31:0] edata);
    chk({tag, "_frame_valid_count"}, 64'(fv_cnt - fv0), 64'(efv));
    chk({tag, "_frame_err_count"}, 64'(fe_cnt - fe0), 64'(efe));
    chk({tag, "_err_code"}, 64'(err_code), 64'(ecode));
    chk({tag, "_frame_data"}, 64'(frame_data), 64'(edata));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic vec_t mk(input logic [63:0] b, input int n, input int fv, input int fe,
                              input logic [2:0] code, input logic [31:0] data);
    vec_t v;
    v.bytes = b; v.n = n; v.exp_fv = fv; v.exp_fe = fe; v.exp_code = code; v.exp_data = data;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(64'h0000_AA66_3322_1155, 6, 1, 0, 3'd0, 32'h6633_2211); // good frame
    vecs[1] = mk(64'h0000_AA67_3322_1155, 6, 0, 1, 3'd3, 32'h6633_2211); // checksum off by one
    vecs[2] = mk(64'h0000_BB66_3322_1155, 6, 0, 1, 3'd2, 32'h6633_2211); // bad tail
    vecs[3] = mk(64'h0000_AA06_0302_0155, 6, 1, 0, 3'd0, 32'h0603_0201); // good, clears code
    vecs[4] = mk(64'hAA66_3322_1155_FF00, 8, 1, 0, 3'd0, 32'h6633_2211); // leading junk
    vecs[5] = mk(64'h0000_BB00_3020_1055, 6, 0, 1, 3'd2, 32'h6633_2211); // tail beats checksum
    vecs[6] = mk(64'h0000_AA00_01AA_5555, 6, 1, 0, 3'd0, 32'h0001_AA55); // header value as data
    vecs[7] = mk(64'h0000_AAFD_FFFF_FF55, 6, 1, 0, 3'd0, 32'hFDFF_FFFF); // checksum wraps

    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    #1;
    chk("reset_byte_data", 64'(byte_data), 64'd0);
    chk("reset_byte_valid", 64'(byte_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_frame_data", 64'(frame_data), 64'd0);
    chk("reset_frame_valid", 64'(frame_valid), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    chk("reset_err_code", 64'(err_code), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold_bits(2);

    for (int v = 0; v < 8; v++) begin
      snap();
      send_bytes(vecs[v].bytes, vecs[v].n);
      settle();
      check_frame($sformatf("vec%0d", v), vecs[v].exp_fv, vecs[v].exp_fe,
                  vecs[v].exp_code, vecs[v].exp_data);
      chk($sformatf("vec%0d_byte_count", v), 64'(bv_cnt - bv0), 64'(vecs[v].n));
      $display("vector %0d: frame_valid=%0d frame_err=%0d err_code=%0d frame_data=%h",
               v, fv_cnt - fv0, fe_cnt - fe0, err_code, frame_data);
    end
    chk("last_byte_data", 64'(byte_data), 64'hAA);

    // Inter-byte timeout: no abort before 20 idle bit periods, abort shortly after.
    snap();
    send_byte(8'h55, 1'b1);
    send_byte(8'h11, 1'b1);
    #1;
    chk("timeout_busy_collecting", 64'(busy), 64'd1);
    hold_bits(17);
    #1;
    chk("timeout_not_early", 64'(fe_cnt - fe0), 64'd0);
    for (int c = 0; c < 8 * BPS && (fe_cnt - fe0) == 0; c++) @(negedge sys_clk);
    settle();
    chk("timeout_frame_err", 64'(fe_cnt - fe0), 64'd1);
    chk("timeout_err_code", 64'(err_code), 64'd4);
    chk("timeout_busy", 64'(busy), 64'd0);
    $display("timeout: frame_err=%0d err_code=%0d busy=%0d", fe_cnt - fe0, err_code, busy);
    snap();
    send_bytes(64'h0000_AA66_3322_1155, 6);
    settle();
    check_frame("after_timeout", 1, 0, 3'd0, 32'h6633_2211);

    // Stop bit low inside a frame aborts with a framing error and yields no byte.
    snap();
    send_byte(8'h55, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    settle();
    check_frame("framing", 0, 1, 3'd1, 32'h6633_2211);
    chk("framing_byte_dropped", 64'(bv_cnt - bv0), 64'd2);
    $display("framing: frame_err=%0d err_code=%0d", fe_cnt - fe0, err_code);

    // A framing error while hunting is not a frame abort.
    snap();
    send_byte(8'h33, 1'b0);
    settle();
    chk("framing_in_hunt_no_err", 64'(fe_cnt - fe0), 64'd0);
    $display("framing in hunt: frame_err=%0d", fe_cnt - fe0);

    // Short low glitch (well under half a bit) must not produce a byte.
    snap();
    uart_rxd = 1'b0;
    repeat (BPS / 3) @(negedge sys_clk);
    uart_rxd = 1'b1;
    hold_bits(12);
    #1;
    chk("glitch_no_byte", 64'(bv_cnt - bv0), 64'd0);
    $display("glitch: byte_valid count=%0d", bv_cnt - bv0);
    snap();
    send_bytes(64'h0000_AA06_0302_0155, 6);
    settle();
    check_frame("after_glitch", 1, 0, 3'd0, 32'h0603_0201);

    // Reset mid-frame clears everything; the next frame is received cleanly.
    send_byte(8'h55, 1'b1);
    send_byte(8'h11, 1'b1);
    uart_rxd = 1'b0;
    hold_bits(3);
    sys_rst_n = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_frame_data", 64'(frame_data), 64'd0);
    chk("midrst_byte_data", 64'(byte_data), 64'd0);
    chk("midrst_err_code", 64'(err_code), 64'd0);
    chk("midrst_pulses", 64'({byte_valid, frame_valid, frame_err}), 64'd0);
    $display("mid-frame reset: busy=%0d frame_data=%h", busy, frame_data);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold_bits(2);
    snap();
    send_bytes(64'h0000_AA66_3322_1155, 6);
    settle();
    check_frame("after_reset", 1, 0, 3'd0, 32'h6633_2211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
